// File: rtl/conv_tree_deserializer.sv
`default_nettype none
// ============================================================================
//  Module   : conv_tree_deserializer
//  Purpose  : Receive side of the convolution tree serializer. Samples one
//             serial bit per clock, aligns to frames on an explicit ALIGN
//             strobe and reassembles OUTPUTS_NUM-bit parallel words, undoing
//             the bit-reversed ordering of the serializer's binary mux tree.
//  Ports    : CLK        - the only clock, rising edge
//             RESET      - asynchronous, active-high reset
//             SERIAL_IN  - serial data, one bit per CLK cycle
//             ALIGN      - marks the SERIAL_IN bit of this cycle as bit 0
//             PAR_OUT    - last complete frame, held until the next one
//             PAR_VALID  - one-cycle pulse when PAR_OUT updates
//             FRAME_ERR  - one-cycle pulse when ALIGN truncates a frame
//             LOCKED     - high once aligned
//  Revision : 1.0 - initial release
// ============================================================================
module conv_tree_deserializer #(
    parameter int OUTPUTS_NUM = 256,
    parameter int STAGES_NUM  = $clog2(OUTPUTS_NUM),
    parameter int BIT_REVERSE = 1
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   SERIAL_IN,
    input  logic                   ALIGN,
    output logic [OUTPUTS_NUM-1:0] PAR_OUT,
    output logic                   PAR_VALID,
    output logic                   FRAME_ERR,
    output logic                   LOCKED
);

    localparam logic [STAGES_NUM-1:0] c_zero = '0;
    localparam logic [STAGES_NUM-1:0] c_one  = STAGES_NUM'(1);
    localparam logic [STAGES_NUM-1:0] c_last = STAGES_NUM'(OUTPUTS_NUM - 1);

    typedef enum logic [0:0] {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } state_t;

    state_t                  r_state;
    logic [STAGES_NUM-1:0]   r_cnt;
    logic [OUTPUTS_NUM-1:0]  r_shadow;
    logic [OUTPUTS_NUM-1:0]  r_par_out;
    logic                    r_par_valid;
    logic                    r_frame_err;
    logic                    r_locked;

    logic [STAGES_NUM-1:0]   w_map;     // shadow position of serial bit r_cnt
    logic [OUTPUTS_NUM-1:0]  w_merged;  // shadow with the current bit folded in

    // Serial bit k belongs at PAR_OUT[bitrev(k)] when the serializer used a
    // binary mux tree; otherwise the order is straight.
    generate
        if (BIT_REVERSE != 0) begin : g_rev
            for (genvar i = 0; i < STAGES_NUM; i++) begin : g_bit
                assign w_map[i] = r_cnt[STAGES_NUM-1-i];
            end
        end else begin : g_fwd
            assign w_map = r_cnt;
        end
    endgenerate

    // The final bit of a frame is published in the same edge it is sampled,
    // so PAR_OUT is loaded from the shadow merged with that bit.
    always_comb begin
        w_merged        = r_shadow;
        w_merged[w_map] = SERIAL_IN;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state     <= ST_UNLOCKED;
            r_cnt       <= c_zero;
            r_shadow    <= '0;
            r_par_out   <= '0;
            r_par_valid <= 1'b0;
            r_frame_err <= 1'b0;
            r_locked    <= 1'b0;
        end else begin
            r_par_valid <= 1'b0;
            r_frame_err <= 1'b0;
            case (r_state)
                ST_UNLOCKED: begin
                    if (ALIGN) begin
                        // map(0) is position 0 in either ordering
                        r_shadow[0] <= SERIAL_IN;
                        r_cnt       <= c_one;
                        r_state     <= ST_LOCKED;
                        r_locked    <= 1'b1;
                    end
                end
                ST_LOCKED: begin
                    if (ALIGN) begin
                        // ALIGN mid-frame drops the partial frame and restarts
                        r_shadow[0] <= SERIAL_IN;
                        r_cnt       <= c_one;
                        if (r_cnt != c_zero) begin
                            r_frame_err <= 1'b1;
                        end
                    end else begin
                        r_shadow[w_map] <= SERIAL_IN;
                        r_cnt           <= r_cnt + c_one;
                        if (r_cnt == c_last) begin
                            r_par_out   <= w_merged;
                            r_par_valid <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state  <= ST_UNLOCKED;
                    r_locked <= 1'b0;
                end
            endcase
        end
    end

    assign PAR_OUT   = r_par_out;
    assign PAR_VALID = r_par_valid;
    assign FRAME_ERR = r_frame_err;
    assign LOCKED    = r_locked;

endmodule
`default_nettype wire
